// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and FSM encoding for the write-back / debug register-file port arbiter.
package wb_port_arbiter_pkg;

  localparam int NB_DATA_DEF     = 32;
  localparam int NB_REG_ADDR_DEF = 5;
  // Wide enough for the largest legal starvation limit (15).
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage (absolute priority) and the
// debug unit; a debug request starved for STARVE_MAX WB cycles stalls the front pipeline.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int NB_REG_ADDR = NB_REG_ADDR_DEF,
  parameter int STARVE_MAX  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   wb_valid_i,
  input  logic [NB_REG_ADDR-1:0] wb_addr_i,
  input  logic [NB_DATA-1:0]     wb_data_i,
  input  logic                   dbg_req_i,
  input  logic                   dbg_we_i,
  input  logic [NB_REG_ADDR-1:0] dbg_addr_i,
  input  logic [NB_DATA-1:0]     dbg_wdata_i,
  output logic                   dbg_ack_o,
  output logic [NB_DATA-1:0]     dbg_rdata_o,
  output logic                   rf_we_o,
  output logic [NB_REG_ADDR-1:0] rf_waddr_o,
  output logic [NB_DATA-1:0]     rf_wdata_o,
  output logic [NB_REG_ADDR-1:0] rf_raddr_o,
  input  logic [NB_DATA-1:0]     rf_rdata_i,
  output logic                   pipe_stall_o
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                we_q;
  logic                from_stall_q;
  logic [NB_DATA-1:0]  rdata_q;
  logic                issue;

  // The debug access goes out only in a WB bubble while the request is still held.
  assign issue   = ((state_q == ST_WAIT) || (state_q == ST_STALL)) && dbg_req_i && !wb_valid_i;
  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      from_stall_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      from_stall_q <= (state_q == ST_STALL);
      if (issue) we_q <= dbg_we_i;
      if ((state_q == ST_RESP) && !we_q) rdata_q <= rf_rdata_i;
    end
  end

  // NOTE: every combinationally written signal gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dbg_req_i) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (!dbg_req_i) begin
          state_d = ST_IDLE;
        end else if (!wb_valid_i) begin
          state_d = ST_RESP;
        end else begin
          if (cnt_q < STARVE_LIM) cnt_d = cnt_inc;
          if (cnt_inc >= STARVE_LIM) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (!dbg_req_i) state_d = ST_IDLE;
        else if (!wb_valid_i) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = wb_addr_i;
    rf_wdata_o = wb_data_i;
    if (wb_valid_i) begin
      rf_we_o = (wb_addr_i != '0);
    end else if (issue && dbg_we_i) begin
      rf_we_o    = (dbg_addr_i != '0);
      rf_waddr_o = dbg_addr_i;
      rf_wdata_o = dbg_wdata_i;
    end
    // Register $0 is hard-wired; reset must also silence a live WB write.
    if (!reset_n_i) rf_we_o = 1'b0;

    rf_raddr_o   = dbg_addr_i;
    dbg_ack_o    = (state_q == ST_RESP);
    // Read data arrives during RESP, so it is forwarded with the ack and then held.
    dbg_rdata_o  = ((state_q == ST_RESP) && !we_q) ? rf_rdata_i : rdata_q;
    pipe_stall_o = (state_q == ST_STALL) || ((state_q == ST_RESP) && from_stall_q);
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter NB_DATA, 32, register-file data width.
REQ-002 Parameter NB_REG_ADDR, 5, register-file address width.
REQ-003 Parameter STARVE_MAX, 4, consecutive pipeline-write cycles a debug request tolerates before a stall is forced (legal range 1..15).
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 reset_n_i  in  1  asynchronous active-low reset.
REQ-006 wb_valid_i  in  1  WB stage writes the register file this cycle.
REQ-007 wb_addr_i  in  NB_REG_ADDR  WB destination register.
REQ-008 wb_data_i  in  NB_DATA  WB write data (WB mux output).
REQ-009 dbg_req_i  in  1  debug-unit access request, held until dbg_ack_o.
REQ-010 dbg_we_i  in  1  1 = write, 0 = read.
REQ-011 dbg_addr_i  in  NB_REG_ADDR  debug register address.
REQ-012 dbg_wdata_i  in  NB_DATA  debug write data.
REQ-013 dbg_ack_o  out  1  one-cycle completion pulse.
REQ-014 dbg_rdata_o  out  NB_DATA  read data, valid with dbg_ack_o, held until next ack.
REQ-015 rf_we_o / rf_waddr_o / rf_wdata_o  out  1 / NB_REG_ADDR / NB_DATA  register-file write port.
REQ-016 rf_raddr_o  out  NB_REG_ADDR  debug read address; rf_rdata_i  in  NB_DATA, valid one cycle after rf_raddr_o.
REQ-017 pipe_stall_o  out  1  freezes IF..MEM; WB drains.

Function
REQ-018 Pipeline has absolute priority: wb_valid_i=1 drives rf_we_o=1, rf_waddr_o=wb_addr_i, rf_wdata_o=wb_data_i combinationally, same cycle, any state.
REQ-019 Any write with address 0 (pipeline or debug) SHALL drive rf_we_o=0; a debug write to $0 is still acknowledged.
REQ-020 FSM states IDLE, WAIT, STALL, RESP.
REQ-021 IDLE: dbg_req_i=1 -> WAIT, starve counter cleared.
REQ-022 WAIT: cycle with wb_valid_i=0 -> debug access issued that cycle (write on rf port, or rf_raddr_o=dbg_addr_i), -> RESP.
REQ-023 WAIT: cycle with wb_valid_i=1 -> counter+1; counter reaching STARVE_MAX -> STALL.
REQ-024 STALL: pipe_stall_o=1; debug access issued in first cycle with wb_valid_i=0, -> RESP.
REQ-025 RESP: dbg_ack_o=1; reads register dbg_rdata_o<=rf_rdata_i; writes leave dbg_rdata_o unchanged; pipe_stall_o stays 1 if entered from STALL; -> IDLE.
REQ-026 dbg_req_i still high in IDLE after RESP counts as a new request.
REQ-027 Debug-access latency: 2 cycles minimum (WAIT issue + RESP) after request registered in IDLE.
REQ-028 dbg_req_i dropped before ack: FSM completes the in-flight sequence only if already issued; otherwise returns to IDLE, no ack, stall released.
REQ-029 Counter saturates at STARVE_MAX; never wraps.

Reset
REQ-030 reset_n_i low: FSM=IDLE, counter=0, dbg_ack_o=0, dbg_rdata_o=0, pipe_stall_o=0, rf_we_o=0 regardless of wb_valid_i.
REQ-031 Reset mid-operation aborts the debug access with no ack; release resumes in IDLE.

Structure
REQ-032 NB_DATA, NB_REG_ADDR and FSM state encodings SHALL live in parameters.vh.
REQ-033 Single module, FSM plus counter inline; no sub-module.

Verification
REQ-034 Idle pipeline, debug write $5=0xDEADBEEF -> rf_we_o with addr 5 one cycle after request, dbg_ack_o next cycle, pipe_stall_o never high.
REQ-035 Debug read $7 holding 0x00001234, wb_valid_i=0 -> dbg_rdata_o=0x00001234 with dbg_ack_o.
REQ-036 wb_valid_i=1 continuously, STARVE_MAX=4, debug write $3 -> pipe_stall_o high after 4 WB cycles, access in first bubble, ack, stall low the cycle after ack.
REQ-037 Simultaneous wb_valid_i=1 ($2=0x11) and debug write ($2=0x22) -> rf port carries 0x11; debug write lands in a later cycle; final $2=0x22.
REQ-038 Debug write $0=0xFFFFFFFF -> rf_we_o stays 0, dbg_ack_o pulses.
REQ-039 reset_n_i asserted in STALL -> pipe_stall_o=0 and no ack; subsequent request completes normally.
